// File: rtl/circular_fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and width helpers.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Bits needed to index DEPTH entries (at least 1).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Bits needed to hold an occupancy of 0..DEPTH.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/circular_fifo_if.sv
// FIFO data/status bundle; the producer/consumer side is master, the FIFO is slave.
interface circular_fifo_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/circular_fifo_ptr_wrap.sv
// Circular pointer: advances on en and wraps DEPTH-1 -> 0 by explicit compare.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  // Pointer register with wrap at the last storage entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == LAST) ptr <= '0;
      else             ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/circular_fifo.sv
// Single-clock circular-buffer FIFO with arbitrary depth, occupancy count,
// almost thresholds, optional first-word-fall-through and sticky error flags.
module circular_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned FWFT            = FIFO_MODE_STD,
  parameter int unsigned ALMOST_FULL_TH  = DEPTH - 1,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input  logic            clk,
  input  logic            reset,
  circular_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(ALMOST_FULL_TH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(ALMOST_EMPTY_TH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("circular_fifo: DEPTH must be at least 2");
  end
  if (ALMOST_FULL_TH > DEPTH) begin : g_bad_af
    $error("circular_fifo: ALMOST_FULL_TH must not exceed DEPTH");
  end
  if (ALMOST_EMPTY_TH >= DEPTH) begin : g_bad_ae
    $error("circular_fifo: ALMOST_EMPTY_TH must be below DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_next;
  logic                  full_q;
  logic                  empty_q;
  logic                  af_q;
  logic                  ae_q;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  rd_acc;
  logic                  wr_acc;

  // Acceptance: a read needs data; a write into a full FIFO needs a same-cycle read.
  always_comb begin
    rd_acc = bus.rd_en & ~empty_q;
    wr_acc = bus.wr_en & (~full_q | rd_acc);
  end

  // Next occupancy from the accepted operations.
  always_comb begin
    count_next = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (rd_acc),
    .ptr   (rd_ptr)
  );

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  // Count and status flags, all derived from count_next so they never lag count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      count_q <= count_next;
      full_q  <= (count_next == CNT_FULL);
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= CNT_AF);
      ae_q    <= (count_next <= CNT_AE);
    end
  end

  // Sticky error flags; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (bus.wr_en & ~wr_acc) | (ovf_q & ~bus.clr_err);
      udf_q <= (bus.rd_en & ~rd_acc) | (udf_q & ~bus.clr_err);
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is presented directly from storage while the FIFO holds data.
    always_comb begin
      bus.rd_data  = mem[rd_ptr];
      bus.rd_valid = ~empty_q;
    end
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read: data appears the cycle after an accepted read.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr];
      end
    end

    // Drive the registered read port.
    always_comb begin
      bus.rd_data  = rd_data_q;
      bus.rd_valid = rd_valid_q;
    end
  end

  // Status outputs.
  always_comb begin
    bus.count        = count_q;
    bus.full         = full_q;
    bus.empty        = empty_q;
    bus.almost_full  = af_q;
    bus.almost_empty = ae_q;
    bus.overflow     = ovf_q;
    bus.underflow    = udf_q;
  end

endmodule
